dmem_arbiter: RTL and testbench



---
 rtl/dmem_arbiter_if.sv | 46 ++++
 rtl/dmem_arbiter.sv | 162 ++++++++++++++++
 tb/tb_dmem_arbiter.sv | 246 ++++++++++++++++++++++++
 3 files changed

// File: rtl/dmem_arbiter_if.sv
// Requester and memory-side bus of the data-memory arbiter.
// The arbiter uses the slave modport; requesters and the memory model use master.
interface dmem_arbiter_if #(
  parameter int unsigned ADDR_W = 64,
  parameter int unsigned DATA_W = 64
) ();
  logic              ReqA;
  logic              WrA;
  logic [ADDR_W-1:0] AddrA;
  logic [DATA_W-1:0] WDataA;
  logic              AckA;
  logic [DATA_W-1:0] RDataA;
  logic              ErrA;

  logic              ReqB;
  logic              WrB;
  logic [ADDR_W-1:0] AddrB;
  logic [DATA_W-1:0] WDataB;
  logic              AckB;
  logic [DATA_W-1:0] RDataB;
  logic              ErrB;

  logic [ADDR_W-1:0] MemAddress;
  logic [DATA_W-1:0] MemDataInput;
  logic              MemWrite;
  logic              MemRead;
  logic [DATA_W-1:0] MemDataOutput;

  modport slave (
    input  ReqA, WrA, AddrA, WDataA,
    output AckA, RDataA, ErrA,
    input  ReqB, WrB, AddrB, WDataB,
    output AckB, RDataB, ErrB,
    output MemAddress, MemDataInput, MemWrite, MemRead,
    input  MemDataOutput
  );

  modport master (
    output ReqA, WrA, AddrA, WDataA,
    input  AckA, RDataA, ErrA,
    output ReqB, WrB, AddrB, WDataB,
    input  AckB, RDataB, ErrB,
    input  MemAddress, MemDataInput, MemWrite, MemRead,
    output MemDataOutput
  );
endinterface

// File: rtl/dmem_arbiter.sv
// Round-robin two-port arbiter/sequencer in front of the 32-word data memory.
// Optional grant/error counters are enabled by defining DMEM_ARB_STATS_EN.
//
// state   | meaning
// IDLE    | wait for a request, pick winner, latch its command
// ACCESS  | one-cycle memory strobe (suppressed on address error)
// CAPTURE | memory output settles; winner's read data loaded at its end
// RESP    | winner's Ack/Err pulse; last-grant updated at its end
module dmem_arbiter #(
  parameter int unsigned ADDR_W    = 64,
  parameter int unsigned DATA_W    = 64,
  parameter int unsigned MEM_DEPTH = 32
) (
  input  logic          Clk,
  input  logic          Reset_n,
  dmem_arbiter_if.slave bus
`ifdef DMEM_ARB_STATS_EN
  ,
  output logic [31:0]   GrantCntA,
  output logic [31:0]   GrantCntB,
  output logic [31:0]   ErrCnt
`endif
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ACCESS  = 2'd1,
    CAPTURE = 2'd2,
    RESP    = 2'd3
  } state_t;

  localparam logic [ADDR_W-1:0] DEPTH_LIM = ADDR_W'(MEM_DEPTH);

  state_t            state_q;
  logic              last_b_q;
  logic              win_b_q;
  logic              wr_q;
  logic              err_q;
  logic [ADDR_W-1:0] mem_addr_q;
  logic [DATA_W-1:0] mem_din_q;
  logic              mem_wr_q;
  logic              mem_rd_q;
  logic              ack_a_q;
  logic              ack_b_q;
  logic              err_a_q;
  logic              err_b_q;
  logic [DATA_W-1:0] rdata_a_q;
  logic [DATA_W-1:0] rdata_b_q;

  logic              grant_b_d;
  logic              sel_wr_d;
  logic [ADDR_W-1:0] sel_addr_d;
  logic [DATA_W-1:0] sel_wdata_d;
  logic              sel_err_d;
  logic [DATA_W-1:0] cap_data_d;

  // On a tie the port that was not granted last time wins.
  always_comb begin
    grant_b_d   = bus.ReqB & (~bus.ReqA | ~last_b_q);
    sel_wr_d    = grant_b_d ? bus.WrB    : bus.WrA;
    sel_addr_d  = grant_b_d ? bus.AddrB  : bus.AddrA;
    sel_wdata_d = grant_b_d ? bus.WDataB : bus.WDataA;
    sel_err_d   = (sel_addr_d >= DEPTH_LIM);
    cap_data_d  = (~wr_q & ~err_q) ? bus.MemDataOutput : '0;
  end

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      state_q    <= IDLE;
      last_b_q   <= 1'b1;
      win_b_q    <= 1'b0;
      wr_q       <= 1'b0;
      err_q      <= 1'b0;
      mem_addr_q <= '0;
      mem_din_q  <= '0;
      mem_wr_q   <= 1'b0;
      mem_rd_q   <= 1'b0;
      ack_a_q    <= 1'b0;
      ack_b_q    <= 1'b0;
      err_a_q    <= 1'b0;
      err_b_q    <= 1'b0;
      rdata_a_q  <= '0;
      rdata_b_q  <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (bus.ReqA | bus.ReqB) begin
            win_b_q    <= grant_b_d;
            wr_q       <= sel_wr_d;
            err_q      <= sel_err_d;
            mem_addr_q <= sel_addr_d;
            mem_din_q  <= sel_wdata_d;
            mem_wr_q   <= sel_wr_d & ~sel_err_d;
            mem_rd_q   <= ~sel_wr_d & ~sel_err_d;
            state_q    <= ACCESS;
          end
        end
        ACCESS: begin
          mem_wr_q <= 1'b0;
          mem_rd_q <= 1'b0;
          state_q  <= CAPTURE;
        end
        CAPTURE: begin
          if (win_b_q) begin
            rdata_b_q <= cap_data_d;
            ack_b_q   <= 1'b1;
            err_b_q   <= err_q;
          end else begin
            rdata_a_q <= cap_data_d;
            ack_a_q   <= 1'b1;
            err_a_q   <= err_q;
          end
          state_q <= RESP;
        end
        RESP: begin
          ack_a_q  <= 1'b0;
          ack_b_q  <= 1'b0;
          err_a_q  <= 1'b0;
          err_b_q  <= 1'b0;
          last_b_q <= win_b_q;
          state_q  <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign bus.MemAddress   = mem_addr_q;
  assign bus.MemDataInput = mem_din_q;
  assign bus.MemWrite     = mem_wr_q;
  assign bus.MemRead      = mem_rd_q;
  assign bus.AckA         = ack_a_q;
  assign bus.AckB         = ack_b_q;
  assign bus.ErrA         = err_a_q;
  assign bus.ErrB         = err_b_q;
  assign bus.RDataA       = rdata_a_q;
  assign bus.RDataB       = rdata_b_q;

`ifdef DMEM_ARB_STATS_EN
  logic [31:0] grant_cnt_a_q;
  logic [31:0] grant_cnt_b_q;
  logic [31:0] err_cnt_q;

  // Counters saturate rather than wrap.
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      grant_cnt_a_q <= '0;
      grant_cnt_b_q <= '0;
      err_cnt_q     <= '0;
    end else if (state_q == RESP) begin
      if (!win_b_q && grant_cnt_a_q != '1) grant_cnt_a_q <= grant_cnt_a_q + 32'd1;
      if (win_b_q && grant_cnt_b_q != '1)  grant_cnt_b_q <= grant_cnt_b_q + 32'd1;
      if (err_q && err_cnt_q != '1)        err_cnt_q     <= err_cnt_q + 32'd1;
    end
  end

  assign GrantCntA = grant_cnt_a_q;
  assign GrantCntB = grant_cnt_b_q;
  assign ErrCnt    = err_cnt_q;
`endif

endmodule

// File: tb/tb_dmem_arbiter.sv
// Directed bench for dmem_arbiter: vector table of single/dual transactions,
// plus round-robin, mid-transaction reset and optional counter sequences.
module tb_dmem_arbiter;

  logic Clk = 1'b0;
  logic Reset_n = 1'b0;

  dmem_arbiter_if #(.ADDR_W(64), .DATA_W(64)) dif ();

`ifdef DMEM_ARB_STATS_EN
  logic [31:0] gca, gcb, ecnt;
`endif

  dmem_arbiter #(.ADDR_W(64), .DATA_W(64), .MEM_DEPTH(32)) dut (
    .Clk     (Clk),
    .Reset_n (Reset_n),
    .bus     (dif)
`ifdef DMEM_ARB_STATS_EN
    ,
    .GrantCntA (gca),
    .GrantCntB (gcb),
    .ErrCnt    (ecnt)
`endif
  );

  always #5 Clk = ~Clk;

  int total = 0;
  int bad = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask

  function automatic logic [63:0] pat(input int i);
    pat = 64'h1111_0000_0000_0000 | 64'(i);
  endfunction

  // 32-word memory model; only the low 5 address bits decode, so an
  // untrapped out-of-range access would alias onto a real word.
  logic [63:0] mem [32];
  logic        mem_init = 1'b0;
  always @(posedge Clk) begin
    if (!mem_init) begin
      for (int i = 0; i < 32; i++) mem[i] <= pat(i);
      mem_init <= 1'b1;
    end else begin
      if (dif.MemWrite) mem[dif.MemAddress[4:0]] <= dif.MemDataInput;
      if (dif.MemRead)  dif.MemDataOutput <= mem[dif.MemAddress[4:0]];
    end
  end

  int          pulse_cnt = 0;
  int          overlap_cnt = 0;
  int          acka_cnt = 0;
  logic [63:0] last_paddr = '0;
  always @(negedge Clk) begin
    if (dif.MemWrite || dif.MemRead) begin
      pulse_cnt++;
      last_paddr = dif.MemAddress;
    end
    if (dif.AckA && dif.AckB) overlap_cnt++;
    if (dif.AckA) acka_cnt++;
  end

  typedef struct {
    logic        ra, wa;
    logic [63:0] aa, da;
    logic        rb, wb;
    logic [63:0] ab, db;
    logic        first_b;
    logic [63:0] rd1;
    logic        er1;
    logic [63:0] rd2;
    logic        er2;
    int          pulses;
    logic [63:0] paddr;
  } vec_t;

  function automatic vec_t mk(
    input logic ra, wa, input logic [63:0] aa, da,
    input logic rb, wb, input logic [63:0] ab, db,
    input logic first_b, input logic [63:0] rd1, input logic er1,
    input logic [63:0] rd2, input logic er2, input int pulses, input logic [63:0] paddr);
    vec_t v;
    v.ra = ra; v.wa = wa; v.aa = aa; v.da = da;
    v.rb = rb; v.wb = wb; v.ab = ab; v.db = db;
    v.first_b = first_b; v.rd1 = rd1; v.er1 = er1; v.rd2 = rd2; v.er2 = er2;
    v.pulses = pulses; v.paddr = paddr;
    return v;
  endfunction

  task automatic run_vec(input vec_t v, input string tag);
    int          nack;
    int          exp_n;
    logic        got_b [2];
    int          lat [2];
    logic [63:0] rd [2];
    logic        er [2];
    @(negedge Clk);
    dif.ReqA = v.ra; dif.WrA = v.wa; dif.AddrA = v.aa; dif.WDataA = v.da;
    dif.ReqB = v.rb; dif.WrB = v.wb; dif.AddrB = v.ab; dif.WDataB = v.db;
    pulse_cnt = 0;
    nack = 0;
    exp_n = int'(v.ra) + int'(v.rb);
    for (int k = 1; k <= 20 && nack < exp_n; k++) begin
      @(negedge Clk);
      if (dif.AckA && nack < 2) begin
        got_b[nack] = 1'b0; lat[nack] = k; rd[nack] = dif.RDataA; er[nack] = dif.ErrA;
        nack++;
        dif.ReqA = 1'b0;
      end
      if (dif.AckB && nack < 2) begin
        got_b[nack] = 1'b1; lat[nack] = k; rd[nack] = dif.RDataB; er[nack] = dif.ErrB;
        nack++;
        dif.ReqB = 1'b0;
      end
    end
    dif.ReqA = 1'b0;
    dif.ReqB = 1'b0;
    chk({tag, " ack count"}, 64'(nack), 64'(exp_n));
    if (nack >= 1) begin
      chk({tag, " first port"}, 64'(got_b[0]), 64'(v.first_b));
      chk({tag, " first latency"}, 64'(lat[0]), 64'd3);
      chk({tag, " first rdata"}, rd[0], v.rd1);
      chk({tag, " first err"}, 64'(er[0]), 64'(v.er1));
    end
    if (exp_n == 2 && nack == 2) begin
      chk({tag, " second port"}, 64'(got_b[1]), 64'(!v.first_b));
      chk({tag, " second latency"}, 64'(lat[1]), 64'd7);
      chk({tag, " second rdata"}, rd[1], v.rd2);
      chk({tag, " second err"}, 64'(er[1]), 64'(v.er2));
    end
    chk({tag, " mem pulses"}, 64'(pulse_cnt), 64'(v.pulses));
    if (v.pulses > 0) chk({tag, " mem addr"}, last_paddr, v.paddr);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  vec_t vecs [11];

  initial begin
    logic        ord_b [4];
    int          ord_k [4];
    int          n;

    vecs[0]  = mk(1, 0, 64'd1, 0, 1, 0, 64'd2, 0, 0, pat(1), 0, pat(2), 0, 2, 64'd2);
    vecs[1]  = mk(1, 1, 64'd5, 64'hDEAD_BEEF_0123_4567, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 64'd5);
    vecs[2]  = mk(1, 0, 64'd5, 0, 0, 0, 0, 0, 0, 64'hDEAD_BEEF_0123_4567, 0, 0, 0, 1, 64'd5);
    vecs[3]  = mk(1, 0, 64'd1, 0, 1, 1, 64'd3, 64'hCAFE_F00D_0000_0003, 1, 0, 0, pat(1), 0, 2, 64'd1);
    vecs[4]  = mk(0, 0, 0, 0, 1, 0, 64'd32, 0, 1, 0, 1, 0, 0, 0, 0);
    vecs[5]  = mk(1, 1, 64'h1_0000_0000, 64'h0BAD, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0);
    vecs[6]  = mk(1, 0, 64'd0, 0, 0, 0, 0, 0, 0, pat(0), 0, 0, 0, 1, 64'd0);
    vecs[7]  = mk(0, 0, 0, 0, 1, 0, 64'd3, 0, 1, 64'hCAFE_F00D_0000_0003, 0, 0, 0, 1, 64'd3);
    vecs[8]  = mk(1, 0, 64'd31, 0, 0, 0, 0, 0, 0, pat(31), 0, 0, 0, 1, 64'd31);
    vecs[9]  = mk(0, 0, 0, 0, 1, 0, 64'hFFFF_FFFF_FFFF_FFFF, 0, 1, 0, 1, 0, 0, 0, 0);
    vecs[10] = mk(1, 1, 64'd7, 64'h77, 1, 0, 64'd7, 0, 0, 0, 0, 64'h77, 0, 2, 64'd7);

    dif.ReqA = 0; dif.WrA = 0; dif.AddrA = '0; dif.WDataA = '0;
    dif.ReqB = 0; dif.WrB = 0; dif.AddrB = '0; dif.WDataB = '0;

    repeat (3) @(negedge Clk);
    chk("reset AckA", 64'(dif.AckA), 0);
    chk("reset ErrB", 64'(dif.ErrB), 0);
    chk("reset MemWrite", 64'(dif.MemWrite), 0);
    chk("reset MemRead", 64'(dif.MemRead), 0);
    chk("reset MemAddress", dif.MemAddress, 0);
    chk("reset RDataA", dif.RDataA, 0);
    Reset_n = 1'b1;

    for (int i = 0; i < 11; i++) run_vec(vecs[i], $sformatf("vec%0d", i));

    // Round-robin with both requests held back-to-back.
    @(negedge Clk);
    Reset_n = 1'b0;
    #1;
    chk("reset RDataB", dif.RDataB, 0);
    @(negedge Clk);
    Reset_n = 1'b1;
    @(negedge Clk);
    dif.ReqA = 1; dif.WrA = 0; dif.AddrA = 64'd1;
    dif.ReqB = 1; dif.WrB = 0; dif.AddrB = 64'd2;
    n = 0;
    for (int k = 1; k <= 30 && n < 4; k++) begin
      @(negedge Clk);
      if (dif.AckA && n < 4) begin
        ord_b[n] = 1'b0; ord_k[n] = k; n++;
        chk("rr RDataA", dif.RDataA, pat(1));
      end
      if (dif.AckB && n < 4) begin
        ord_b[n] = 1'b1; ord_k[n] = k; n++;
        chk("rr RDataB", dif.RDataB, pat(2));
      end
    end
    dif.ReqA = 0; dif.ReqB = 0;
    chk("rr grant count", 64'(n), 64'd4);
    for (int i = 0; i < n; i++) begin
      chk($sformatf("rr order %0d", i), 64'(ord_b[i]), 64'(i % 2));
      chk($sformatf("rr cycle %0d", i), 64'(ord_k[i]), 64'(3 + 4 * i));
    end

    // Reset asserted during CAPTURE of a port A read.
    @(negedge Clk);
    dif.ReqA = 1; dif.WrA = 0; dif.AddrA = 64'd1;
    @(negedge Clk);
    @(negedge Clk);
    chk("midrst capture addr", dif.MemAddress, 64'd1);
    Reset_n = 1'b0;
    dif.ReqA = 0;
    #1;
    acka_cnt = 0;
    chk("midrst AckA", 64'(dif.AckA), 0);
    chk("midrst RDataA", dif.RDataA, 0);
    chk("midrst MemAddress", dif.MemAddress, 0);
    chk("midrst MemDataInput", dif.MemDataInput, 0);
    chk("midrst MemRead", 64'(dif.MemRead), 0);
    repeat (2) @(negedge Clk);
    Reset_n = 1'b1;
    repeat (4) @(negedge Clk);
    chk("midrst no AckA", 64'(acka_cnt), 0);
    run_vec(mk(0, 0, 0, 0, 1, 0, 64'd2, 0, 1, pat(2), 0, 0, 0, 1, 64'd2), "post-reset B");
`ifdef DMEM_ARB_STATS_EN
    @(negedge Clk);
    chk("stats GrantCntA", 64'(gca), 0);
    chk("stats GrantCntB", 64'(gcb), 1);
    chk("stats ErrCnt", 64'(ecnt), 0);
    run_vec(mk(0, 0, 0, 0, 1, 0, 64'd32, 0, 1, 0, 1, 0, 0, 0, 0), "stats err B");
    @(negedge Clk);
    chk("stats GrantCntB err", 64'(gcb), 2);
    chk("stats ErrCnt err", 64'(ecnt), 1);
`endif

    chk("ack overlap", 64'(overlap_cnt), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
